hex_word_ascii_streamer: RTL and testbench
==========================================

Name: hex_word_ascii_streamer

Overview:
- Converts a DATA_WIDTH-bit binary word into a stream of ASCII hex characters, one byte per handshake, MSB nibble first.
- Optional "0x" prefix, optional CR/LF terminator, selectable upper/lower case for A–F.
- Parametrised sequential successor to the single-nibble combinational hex-to-ASCII converter.
- Sits between debug/status sources and the UART TX byte interface.

Parameters:
- DATA_WIDTH, 32, input word width; multiple of 4, range 4..64; NDIG = DATA_WIDTH/4.
- PREFIX_EN, 1, 1 = emit "0x" (0x30, 0x78) before the digits.
- NEWLINE_EN, 1, 1 = emit CR (0x0D) then LF (0x0A) after the digits.
- UPPERCASE, 1, 1 = A–F map to 0x41–0x46; 0 = a–f map to 0x61–0x66. The prefix 'x' is always 0x78.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  word to convert; sampled on accept.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word.
- out_char  output  8  ASCII byte.
- out_valid  output  1  out_char valid.
- out_ready  input  1  downstream accepts out_char.
- out_last  output  1  marks the final byte of the current word.
- busy  output  1  high while a word is being emitted.

Behaviour:
- Reset values (rst high at a clock edge): state IDLE, out_valid=0, out_char=8'h00, out_last=0, busy=0, word register and digit counter cleared. in_ready = (state==IDLE) && !rst.
- Reset mid-word: emission aborts on the next edge. The partially sent word is discarded, with no further bytes and no out_last.
- Accept: a word is accepted when in_valid && in_ready at a rising edge. in_data is latched and the digit counter loads NDIG-1. in_ready is low in every state except IDLE.
- FSM states: IDLE -> PFX0 -> PFXX -> DIGIT -> CR -> LF -> IDLE.
  - PFX0/PFXX are skipped when PREFIX_EN=0.
  - CR/LF are skipped when NEWLINE_EN=0.
  - All outputs are registered.
- Latency: out_valid rises in the cycle after accept. out_char holds the first byte (the prefix '0' or the MSB digit).
- Transfer rules:
  - A byte transfers when out_valid && out_ready.
  - The state advances only on a transfer.
  - While out_valid && !out_ready, out_char and out_last are held stable and the state holds.
- DIGIT state:
  - Nibble select = word[4*cnt+3 : 4*cnt].
  - Mapping: 0–9 -> 0x30–0x39; 10–15 -> per UPPERCASE.
  - cnt decrements on each transfer. On transfer with cnt==0, move to the next state.
- out_last: high together with the final byte of the word (LF if NEWLINE_EN, else the LSB digit).
- End of word: on the transfer of the out_last byte, out_valid=0 and state=IDLE on the next edge. busy = (state != IDLE).
- Per-word count: NDIG + 2*PREFIX_EN + 2*NEWLINE_EN bytes.
- Throughput: with out_ready tied high, one byte per cycle and one idle cycle between words (minimum word period N+1 cycles).
- Boundaries:
  - DATA_WIDTH=4 gives a single digit; cnt is then 0 from the start.
  - out_ready may toggle every cycle; no byte is ever duplicated or dropped.
  - in_valid while busy is ignored (no accept). in_data may change freely while busy.

Test Plan:
- DATA_WIDTH=16, defaults, in_data=16'h1A2F, out_ready=1 -> bytes 0x30,0x78,0x31,0x41,0x32,0x46,0x0D,0x0A in 8 consecutive cycles; out_last only on 0x0A; in_ready returns 1 one cycle after.
- DATA_WIDTH=32, defaults, words 32'h01234567 then 32'h89ABCDEF -> all 16 digit codes correct (0x30–0x39, 0x41–0x46); the second word is accepted only after the first word's out_last transfer.
- Same 32'h89ABCDEF with UPPERCASE=0, PREFIX_EN=0, NEWLINE_EN=0 -> 0x38,0x39,0x61,0x62,0x63,0x64,0x65,0x66; out_last on 0x66.
- Backpressure: 16'hBEEF with out_ready pseudo-random (about 50%) -> byte sequence identical to the out_ready=1 case; out_char stable through every stall; no duplicates.
- Reset mid-word: assert rst for 1 cycle after the 3rd byte of 16'h1234 -> out_valid=0 and in_ready=1 next cycle. A new word 16'h00FF then produces its full 8-byte sequence from "0x".
- Edge: DATA_WIDTH=4, NEWLINE_EN=0, PREFIX_EN=0, sweep in_data 0..15 -> single byte each with out_last=1, matching the 0–9/A–F table.

Source files
------------

// File: rtl/hex_word_ascii_streamer.sv
// -----------------------------------------------------------------------------
// hex_word_ascii_streamer
//
// Turns a DATA_WIDTH-bit word into a stream of ASCII hex characters, one byte
// per valid/ready handshake, most significant nibble first. An optional "0x"
// prefix and an optional CR/LF terminator surround the digits. Letters A-F are
// emitted in upper or lower case. Intended to sit between debug/status
// sources and a UART TX byte interface.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_data    word to convert, captured when accepted
//   in_valid   in_data valid
//   in_ready   block is idle and can accept a word
//   out_char   ASCII byte (registered)
//   out_valid  out_char valid (registered)
//   out_ready  downstream accepts out_char
//   out_last   marks the final byte of the current word (registered)
//   busy       a word is being emitted
// -----------------------------------------------------------------------------
module hex_word_ascii_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int PREFIX_EN  = 1,
    parameter int NEWLINE_EN = 1,
    parameter int UPPERCASE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_char,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);

    localparam int NDIG = DATA_WIDTH / 4;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PFX0  = 3'd1;
    localparam logic [2:0] S_PFXX  = 3'd2;
    localparam logic [2:0] S_DIGIT = 3'd3;
    localparam logic [2:0] S_CR    = 3'd4;
    localparam logic [2:0] S_LF    = 3'd5;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] word_nxt;
    logic [3:0]            nib;
    logic                  xfer;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else if (UPPERCASE != 0)
            return 8'h37 + {4'h0, n};   // 10 -> 0x41 'A'
        else
            return 8'h57 + {4'h0, n};   // 10 -> 0x61 'a'
    endfunction

    function automatic logic [7:0] state_byte(input logic [2:0] s, input logic [3:0] n);
        case (s)
            S_PFX0:  return 8'h30;
            S_PFXX:  return 8'h78;
            S_DIGIT: return hex_ascii(n);
            S_CR:    return 8'h0D;
            S_LF:    return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    assign xfer     = out_valid && out_ready;
    assign in_ready = (state == S_IDLE) && !rst;
    assign busy     = (state != S_IDLE);

    // Next-state logic. Each non-idle state stands for the byte currently on
    // out_char; the registered outputs are derived from the *next* state so
    // they line up with it, and simply reload the same value during a stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    word_nxt  = in_data;
                    cnt_nxt   = CW'(NDIG - 1);
                    state_nxt = (PREFIX_EN != 0) ? S_PFX0 : S_DIGIT;
                end
            end
            S_PFX0:  if (xfer) state_nxt = S_PFXX;
            S_PFXX:  if (xfer) state_nxt = S_DIGIT;
            S_DIGIT: begin
                if (xfer) begin
                    if (cnt == '0)
                        state_nxt = (NEWLINE_EN != 0) ? S_CR : S_IDLE;
                    else
                        cnt_nxt = cnt - CW'(1);
                end
            end
            S_CR:    if (xfer) state_nxt = S_LF;
            S_LF:    if (xfer) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Nibble mux on the next word/counter, so the digit is ready to register.
    always_comb begin
        nib = 4'h0;
        for (int k = 0; k < NDIG; k++) begin
            if (cnt_nxt == CW'(k))
                nib = word_nxt[4*k +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            word      <= '0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            word      <= word_nxt;
            out_valid <= (state_nxt != S_IDLE);
            out_char  <= state_byte(state_nxt, nib);
            // Final byte is LF when the terminator is on, else the LSB digit.
            out_last  <= (state_nxt == S_LF) ||
                         ((NEWLINE_EN == 0) && (state_nxt == S_DIGIT) && (cnt_nxt == '0));
        end
    end

endmodule

// File: tb/tb_hex_word_ascii_streamer.sv
module tb_hex_word_ascii_streamer;

    logic        clk;
    logic        rst;
    logic [63:0] din;
    logic [3:0]  iv;
    logic        out_ready;
    logic        bp_en;

    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  ol;
    logic [3:0]  by;
    logic [7:0]  oc [4];

    // Instance configurations: width, prefix, newline, uppercase
    int cfg_w [4] = '{16, 32, 32, 4};
    int cfg_p [4] = '{1, 1, 0, 0};
    int cfg_n [4] = '{1, 1, 0, 0};
    int cfg_u [4] = '{1, 1, 0, 1};

    int n_cmp = 0;
    int n_err = 0;

    // Captured transfers per instance
    logic [7:0] cap_b [4][0:1023];
    bit         cap_l [4][0:1023];
    int         cap_c [4][0:1023];
    int         cap_n [4];
    int         cyc;
    bit   [3:0] pstall;
    logic [7:0] pchar [4];
    logic [3:0] plast;

    // Expected byte list for the current word
    logic [7:0] exp_b [0:31];
    int         exp_n;

    hex_word_ascii_streamer #(.DATA_WIDTH(16), .PREFIX_EN(1), .NEWLINE_EN(1), .UPPERCASE(1)) u0 (
        .clk(clk), .rst(rst), .in_data(din[15:0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_char(oc[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_last(ol[0]), .busy(by[0]));

    hex_word_ascii_streamer #(.DATA_WIDTH(32), .PREFIX_EN(1), .NEWLINE_EN(1), .UPPERCASE(1)) u1 (
        .clk(clk), .rst(rst), .in_data(din[31:0]), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_char(oc[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_last(ol[1]), .busy(by[1]));

    hex_word_ascii_streamer #(.DATA_WIDTH(32), .PREFIX_EN(0), .NEWLINE_EN(0), .UPPERCASE(0)) u2 (
        .clk(clk), .rst(rst), .in_data(din[31:0]), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_char(oc[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_last(ol[2]), .busy(by[2]));

    hex_word_ascii_streamer #(.DATA_WIDTH(4), .PREFIX_EN(0), .NEWLINE_EN(0), .UPPERCASE(1)) u3 (
        .clk(clk), .rst(rst), .in_data(din[3:0]), .in_valid(iv[3]), .in_ready(ir[3]),
        .out_char(oc[3]), .out_valid(ov[3]), .out_ready(out_ready), .out_last(ol[3]), .busy(by[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // out_ready: constant high, or a coin toss each cycle under backpressure
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: record every transfer, check stability across stalls
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (pstall[i] && ov[i]) begin
                chk("hold_char", 64'(oc[i]), 64'(pchar[i]));
                chk("hold_last", 64'(ol[i]), 64'(plast[i]));
            end
            if (ov[i] && out_ready && cap_n[i] < 1024) begin
                cap_b[i][cap_n[i]] = oc[i];
                cap_l[i][cap_n[i]] = ol[i];
                cap_c[i][cap_n[i]] = cyc;
                cap_n[i]++;
            end
            pstall[i] = ov[i] && !out_ready;
            pchar[i]  = oc[i];
            plast[i]  = ol[i];
        end
    end

    // Reference: prefix, hex digits MSB first, terminator
    task automatic model(input logic [63:0] w, input int i);
        int nd;
        int d;
        nd    = cfg_w[i] / 4;
        exp_n = 0;
        if (cfg_p[i] != 0) begin
            exp_b[exp_n] = 8'h30; exp_n++;
            exp_b[exp_n] = 8'h78; exp_n++;
        end
        for (int k = nd - 1; k >= 0; k--) begin
            d = int'((w >> (4 * k)) & 64'hF);
            if (d < 10) exp_b[exp_n] = 8'(48 + d);
            else        exp_b[exp_n] = 8'(((cfg_u[i] != 0) ? 65 : 97) + d - 10);
            exp_n++;
        end
        if (cfg_n[i] != 0) begin
            exp_b[exp_n] = 8'h0D; exp_n++;
            exp_b[exp_n] = 8'h0A; exp_n++;
        end
    endtask

    task automatic wait_ready(input int i);
        int t;
        t = 0;
        while (!ir[i] && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!ir[i]) chk("ready_timeout", 64'(ir[i]), 64'd1);
    endtask

    task automatic accept(input int i, input logic [63:0] w);
        @(negedge clk); #1;
        din   = w;
        iv[i] = 1'b1;
        @(posedge clk); #1;
        iv[i] = 1'b0;
        din   = {$urandom, $urandom};   // data may change freely while busy
    endtask

    task automatic run_word(input int i, input logic [63:0] w, input bit pulse, output int base);
        int t;
        model(w, i);
        wait_ready(i);
        base = cap_n[i];
        accept(i, w);
        chk("first_valid", 64'(ov[i]), 64'd1);
        chk("first_char", 64'(oc[i]), 64'(exp_b[0]));
        if (pulse) begin
            for (int p = 0; p < 3; p++) begin
                @(negedge clk); #1;
                iv[i] = 1'b1;
                chk("ready_busy", 64'(ir[i]), 64'd0);
                @(posedge clk); #1;
                iv[i] = 1'b0;
            end
        end
        t = 0;
        while ((cap_n[i] - base) < exp_n && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        chk("byte_count", 64'(cap_n[i] - base), 64'(exp_n));
        for (int k = 0; k < exp_n; k++) begin
            chk("byte", 64'(cap_b[i][base + k]), 64'(exp_b[k]));
            chk("last", 64'(cap_l[i][base + k]), 64'(k == exp_n - 1));
            if (!bp_en)
                chk("cycle", 64'(cap_c[i][base + k] - cap_c[i][base]), 64'(k));
        end
        chk("end_valid", 64'(ov[i]), 64'd0);
        chk("end_ready", 64'(ir[i]), 64'd1);
    endtask

    initial begin
        int base;
        int t;
        logic [7:0] ref_a [8] = '{8'h30, 8'h78, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
        logic [7:0] ref_b [8] = '{8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        logic [7:0] ref_c [3] = '{8'h30, 8'h78, 8'h31};

        rst   = 1'b1;
        din   = '0;
        iv    = '0;
        bp_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_valid", 64'(ov[i]), 64'd0);
            chk("rst_char", 64'(oc[i]), 64'd0);
            chk("rst_last", 64'(ol[i]), 64'd0);
            chk("rst_busy", 64'(by[i]), 64'd0);
            chk("rst_ready", 64'(ir[i]), 64'd0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk("idle_ready", 64'(ir[i]), 64'd1);

        // 16-bit word with prefix and terminator, plus known constant bytes
        run_word(0, 64'h1A2F, 1'b1, base);
        for (int k = 0; k < 8; k++) chk("const_1a2f", 64'(cap_b[0][base + k]), 64'(ref_a[k]));

        // 32-bit back-to-back words
        run_word(1, 64'h01234567, 1'b1, base);
        run_word(1, 64'h89ABCDEF, 1'b0, base);

        // Lowercase, no prefix, no terminator
        run_word(2, 64'h89ABCDEF, 1'b0, base);
        for (int k = 0; k < 8; k++) chk("const_lower", 64'(cap_b[2][base + k]), 64'(ref_b[k]));

        // Backpressure
        bp_en = 1'b1;
        run_word(0, 64'hBEEF, 1'b1, base);
        for (int n = 0; n < 12; n++) run_word(0, {$urandom, $urandom}, 1'b0, base);
        for (int n = 0; n < 6; n++)  run_word(1, {$urandom, $urandom}, 1'b1, base);
        for (int n = 0; n < 6; n++)  run_word(2, {$urandom, $urandom}, 1'b0, base);
        for (int n = 0; n < 8; n++)  run_word(3, {$urandom, $urandom}, 1'b0, base);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a word
        wait_ready(0);
        base = cap_n[0];
        accept(0, 64'h1234);
        t = 0;
        while ((cap_n[0] - base) < 3 && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 64'(ov[0]), 64'd0);
        chk("midrst_busy", 64'(by[0]), 64'd0);
        chk("midrst_char", 64'(oc[0]), 64'd0);
        chk("midrst_last", 64'(ol[0]), 64'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", 64'(ir[0]), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_count", 64'(cap_n[0] - base), 64'd3);
        for (int k = 0; k < 3; k++) begin
            chk("midrst_byte", 64'(cap_b[0][base + k]), 64'(ref_c[k]));
            chk("midrst_nolast", 64'(cap_l[0][base + k]), 64'd0);
        end
        run_word(0, 64'h00FF, 1'b0, base);

        // Single-digit sweep
        for (int v = 0; v < 16; v++) run_word(3, 64'(v), 1'b0, base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
